apb_master_bridge: RTL and testbench

APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

---
 rtl/apb_master_bridge.sv | 169 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Single-request host-to-APB bridge: decodes the slave from the upper address bits and runs one SETUP/ACCESS transfer.
// Optional ACCESS wait timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SLV_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic                      req_write,
    input  logic [DATA_W-1:0]         req_wdata,
    input  logic [DATA_W/8-1:0]       req_strb,
    input  logic [2:0]                req_prot,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_slverr,
    output logic [ADDR_W-1:0]         paddr,
    output logic [2:0]                pprot,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int IDXF_W = ADDR_W - SLV_AW;
    localparam int CMP_W  = (IDXF_W > 6) ? IDXF_W : 6;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic                write_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   strb_reg;
    logic [2:0]          prot_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                slverr_reg;

    logic                accept;
    logic                decode_ok;
    logic                sel_active;
    logic                sel_ready;
    logic                sel_err;
    logic                timeout_hit;
    logic [IDXF_W-1:0]   idx_full;
    logic [DATA_W-1:0]   sel_rdata;
    logic [DATA_W-1:0]   slv_rdata [NUM_SLV];

    assign accept    = req_valid && req_ready;
    assign idx_full  = req_addr[ADDR_W-1:SLV_AW];
    assign decode_ok = CMP_W'(idx_full) < CMP_W'(NUM_SLV);

    // Only the addressed slave's response lines are ever looked at.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign slv_rdata[gi] = prdata[gi*DATA_W +: DATA_W];
            assign psel[gi]      = sel_active && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign sel_rdata = slv_rdata[idx_reg];
    assign sel_ready = pready[idx_reg];
    assign sel_err   = pslverr[idx_reg];

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;

    assign timeout_hit = (state_reg == ACCESS) && !sel_ready &&
                         (wait_cnt_reg == 16'(TIMEOUT - 1));

    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt_reg <= '0;
        end else if (accept && decode_ok) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !sel_ready) begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = decode_ok ? SETUP : RESP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (sel_ready || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        sel_active = 1'b0;
        penable    = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            IDLE:    req_ready = !preset;
            SETUP:   sel_active = 1'b1;
            ACCESS: begin
                sel_active = 1'b1;
                penable    = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // A decode miss is answered straight from IDLE, so the error flag is preset at acceptance.
    always_ff @(posedge pclk) begin
        if (preset) begin
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            wdata_reg  <= '0;
            strb_reg   <= '0;
            prot_reg   <= '0;
            idx_reg    <= '0;
            rdata_reg  <= '0;
            slverr_reg <= 1'b0;
        end else if (accept) begin
            addr_reg   <= req_addr;
            write_reg  <= req_write;
            wdata_reg  <= req_wdata;
            strb_reg   <= req_strb;
            prot_reg   <= req_prot;
            idx_reg    <= decode_ok ? idx_full[IDX_W-1:0] : '0;
            rdata_reg  <= '0;
            slverr_reg <= !decode_ok;
        end else if (state_reg == ACCESS && sel_ready) begin
            rdata_reg  <= write_reg ? '0 : sel_rdata;
            slverr_reg <= sel_err;
        end else if (timeout_hit) begin
            rdata_reg  <= '0;
            slverr_reg <= 1'b1;
        end
    end

    assign paddr      = addr_reg;
    assign pprot      = prot_reg;
    assign pwrite     = write_reg;
    assign pwdata     = wdata_reg;
    assign pstrb      = write_reg ? strb_reg : '0;
    assign rsp_rdata  = rsp_valid ? rdata_reg : '0;
    assign rsp_slverr = rsp_valid && slverr_reg;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: four slaves driven from per-transaction tables, expected values written by hand.
module tb_apb_master_bridge;
    logic         pclk;
    logic         preset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_write;
    logic [31:0]  req_wdata;
    logic [3:0]   req_strb;
    logic [2:0]   req_prot;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_slverr;
    logic [31:0]  paddr;
    logic [2:0]   pprot;
    logic [3:0]   psel;
    logic         penable;
    logic         pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [127:0] prdata;
    logic [3:0]   pready;
    logic [3:0]   pslverr;

    int n_checks = 0;
    int n_err    = 0;

    apb_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_AW(12), .TIMEOUT(8)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    // Presents one request, lets it be accepted, then scribbles over req_* while busy.
    task automatic start_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [3:0] st, input logic [2:0] pr);
        @(negedge pclk);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        req_strb  = st;
        req_prot  = pr;
        req_valid = 1'b1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        req_addr  = 32'h0000_2000;
        req_write = ~wr;
        req_wdata = 32'h5555_5555;
        req_strb  = 4'h0;
    endtask

    task automatic run_txn(input string name, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                           input int tgt, input int wait_n, input logic [31:0] sdata,
                           input logic serr, input logic noise, input logic [3:0] exp_psel,
                           input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int   c;
        int   lat;
        logic got;
        logic strb_bad;
        logic multi;
        pready  = 4'h0;
        pslverr = 4'h0;
        prdata  = '0;
        prdata[tgt*32 +: 32] = sdata;
        pslverr[tgt] = serr;
        if (noise) begin
            pready[0]     = 1'b1;
            pslverr[0]    = 1'b1;
            prdata[31:0]  = 32'hBAD0_BAD0;
        end
        start_req(addr, wr, wd, st, pr);
        c = 1; lat = 0; got = 1'b0; strb_bad = 1'b0; multi = 1'b0;
        while (!got && c <= 60) begin
            if ($countones(psel) > 1) multi = 1'b1;
            if (!wr && pstrb != 4'h0) strb_bad = 1'b1;
            if (c == 1 && exp_lat > 1) begin
                check({name, "_setup_psel"}, 64'(psel), 64'(exp_psel));
                check({name, "_setup_penable"}, 64'(penable), 64'd0);
                check({name, "_setup_paddr"}, 64'(paddr), 64'(addr));
                check({name, "_setup_pstrb"}, 64'(pstrb), 64'(wr ? st : 4'h0));
            end
            if (c == 2 && exp_lat > 2) begin
                check({name, "_access_psel"}, 64'(psel), 64'(exp_psel));
                check({name, "_access_penable"}, 64'(penable), 64'd1);
                check({name, "_access_pwrite"}, 64'(pwrite), 64'(wr));
                check({name, "_access_pprot"}, 64'(pprot), 64'(pr));
                if (wr) check({name, "_access_pwdata"}, 64'(pwdata), 64'(wd));
            end
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                check({name, "_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
                check({name, "_slverr"}, 64'(rsp_slverr), 64'(exp_err));
                check({name, "_resp_psel"}, 64'(psel), 64'd0);
                check({name, "_resp_penable"}, 64'(penable), 64'd0);
            end else begin
                pready[tgt] = (c >= 2 + wait_n);
                @(negedge pclk);
                c++;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_onehot"}, 64'(multi), 64'd0);
        if (!wr) check({name, "_read_pstrb"}, 64'(strb_bad), 64'd0);
        pready = 4'h0;
        @(negedge pclk);
        check({name, "_pulse_end"}, 64'(rsp_valid), 64'd0);
        check({name, "_back_idle"}, 64'(req_ready), 64'd1);
        $display("txn %s addr=%h wr=%0d lat=%0d rdata=%h slverr=%0d", name, addr, wr, lat,
                 exp_rdata, exp_err);
    endtask

    initial begin
        logic saw_rsp;
        preset = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_strb = '0; req_prot = '0;
        prdata = '0; pready = '0; pslverr = '0;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        preset = 1'b0;
        @(negedge pclk);
        check("post_rst_ready", 64'(req_ready), 64'd1);

        run_txn("wr_s1", 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010,
                1, 0, 32'hAAAA_5555, 1'b0, 1'b0, 4'b0010, 3, 32'h0, 1'b0);
        run_txn("rd_s3", 32'h0000_3000, 1'b0, 32'h0, 4'hF, 3'b001,
                3, 2, 32'h1234_5678, 1'b0, 1'b0, 4'b1000, 5, 32'h1234_5678, 1'b0);
        run_txn("decerr", 32'h0000_5000, 1'b0, 32'h0, 4'h0, 3'b000,
                0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0000, 1, 32'h0, 1'b1);
        run_txn("rd_s2_noise", 32'h0000_2010, 1'b0, 32'h0, 4'h0, 3'b100,
                2, 1, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b0100, 4, 32'hCAFE_F00D, 1'b0);
        run_txn("rd_s0_err", 32'h0000_0008, 1'b0, 32'h0, 4'h0, 3'b000,
                0, 0, 32'h0000_BEEF, 1'b1, 1'b0, 4'b0001, 3, 32'h0000_BEEF, 1'b1);
        run_txn("wr_s3_strb", 32'h0000_3FFC, 1'b1, 32'h0102_0304, 4'h3, 3'b111,
                3, 0, 32'h9999_9999, 1'b0, 1'b0, 4'b1000, 3, 32'h0, 1'b0);

`ifdef APB_BRIDGE_TIMEOUT_EN
        run_txn("timeout", 32'h0000_0000, 1'b0, 32'h0, 4'h0, 3'b000,
                0, 1000, 32'h7777_7777, 1'b0, 1'b0, 4'b0001, 10, 32'h0, 1'b1);
`else
        pready = 4'h0; pslverr = 4'h0; prdata = '0;
        start_req(32'h0000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
        saw_rsp = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("hang_no_rsp", 64'(saw_rsp), 64'd0);
        check("hang_penable", 64'(penable), 64'd1);
        check("hang_psel", 64'(psel), 64'h1);
        preset = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        check("hang_recover_ready", 64'(req_ready), 64'd1);
        $display("txn hang addr=00000000 cycles=100 rsp=%0d", saw_rsp);
`endif

        // Reset lands in the second ACCESS cycle of a read to slave 1.
        pready = 4'h0; pslverr = 4'h0; prdata = '0;
        start_req(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        @(negedge pclk);
        check("abort_pre_penable", 64'(penable), 64'd1);
        preset = 1'b1;
        @(negedge pclk);
        check("abort_psel", 64'(psel), 64'd0);
        check("abort_penable", 64'(penable), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_req_ready", 64'(req_ready), 64'd0);
        preset = 1'b0;
        pready[1] = 1'b1;
        saw_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("abort_no_rsp", 64'(saw_rsp), 64'd0);
        $display("txn abort addr=00001000 rsp=%0d", saw_rsp);
        run_txn("rd_s1_after", 32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000,
                1, 0, 32'h600D_F00D, 1'b0, 1'b0, 4'b0010, 3, 32'h600D_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
